// File: rtl/div_float_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states,
// flag bit positions, default field widths and the canonical quiet NaN.
package div_float_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int FLAG_NV = 3;
    localparam int FLAG_DZ = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_UF = 0;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_FRAC_W = 23;

    // Canonical qNaN (sign 0, exponent all ones, fraction MSB set), returned
    // right-aligned in a 64-bit word; callers keep the low 1+exp_w+frac_w bits.
    function automatic logic [63:0] canonical_nan(input int exp_w, input int frac_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << frac_w;
        v = v | (64'd1 << (frac_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/div_float_iter_step.sv
// One restoring-division step: subtract the divisor when it fits, emit the
// quotient bit and return the remainder shifted left for the next step.
module div_float_iter_step #(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    output logic             q_bit,
    output logic [WIDTH-1:0] rem_next
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] kept;

    // Trial subtraction; a clear borrow bit means the divisor fits.
    always_comb begin
        trial    = {1'b0, rem} - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        kept     = q_bit ? trial[WIDTH-1:0] : rem;
        rem_next = kept << 1;
    end

endmodule

// File: rtl/div_float_iter.sv
// Multi-cycle IEEE-754 divider, one quotient bit per clock, valid/ready on
// both sides. Denormal operands are flushed to zero.
// Optional feature: define DIV_FLOAT_ITER_RNE_EN for round-to-nearest-even;
// otherwise the result is truncated (matches the legacy combinational divider).
module div_float_iter
    import div_float_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   op1,
    input  logic [EXP_W+FRAC_W:0]   op2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   res,
    output logic [3:0]              flags
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int N     = FRAC_W + 3;
    localparam int RW    = FRAC_W + 2;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(N);

    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = EW'(0);
    localparam logic [63:0]          NAN_WIDE = canonical_nan(EXP_W, FRAC_W);
    localparam logic [W-1:0]         NAN_VAL  = NAN_WIDE[W-1:0];

    state_e                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           res_q, res_d;
    logic [3:0]             flags_q, flags_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [FRAC_W:0]        dvs_q, dvs_d;
    logic [N-1:0]           quo_q, quo_d;

    logic                   step_bit;
    logic [RW-1:0]          step_rem;

    // Operand field decode
    logic                   s1, s2;
    logic [EXP_W-1:0]       e1, e2;
    logic [FRAC_W-1:0]      f1, f2;
    logic                   a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    // Normalise / round intermediates
    logic [N-1:0]           quo_n;
    logic signed [EW-1:0]   e_n, e_r;
    logic [FRAC_W:0]        sig;
    logic                   guard, sticky, round_inc;
    logic [FRAC_W+1:0]      sum;
    logic [FRAC_W-1:0]      frac_r;

    div_float_iter_step #(.WIDTH(RW)) u_step (
        .rem      (rem_q),
        .divisor  ({1'b0, dvs_q}),
        .q_bit    (step_bit),
        .rem_next (step_rem)
    );

    // Next-state, datapath and registered-output logic for the whole FSM.
    always_comb begin
        s1 = op1[W-1];
        s2 = op2[W-1];
        e1 = op1[W-2:FRAC_W];
        e2 = op2[W-2:FRAC_W];
        f1 = op1[FRAC_W-1:0];
        f2 = op2[FRAC_W-1:0];
        a_nan  = (&e1) & (|f1);
        a_inf  = (&e1) & ~(|f1);
        a_zero = ~(|e1);
        b_nan  = (&e2) & (|f2);
        b_inf  = (&e2) & ~(|f2);
        b_zero = ~(|e2);

        // Normalise: a leading zero quotient bit costs one exponent step.
        quo_n  = quo_q[N-1] ? quo_q : (quo_q << 1);
        e_n    = quo_q[N-1] ? e_q : (e_q - ONE_S);
        sig    = quo_n[N-1:2];
        guard  = quo_n[1];
        sticky = quo_n[0] | (|rem_q);
`ifdef DIV_FLOAT_ITER_RNE_EN
        round_inc = guard & (sticky | sig[0]);
`else
        round_inc = 1'b0 & (guard | sticky);
`endif
        sum    = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, round_inc};
        frac_r = sum[FRAC_W+1] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
        e_r    = sum[FRAC_W+1] ? (e_n + ONE_S) : e_n;

        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        e_d         = e_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d     = s1 ^ s2;
                    in_ready_d = 1'b0;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        res_d   = NAN_VAL;
                        flags_d = 4'(1 << FLAG_NV);
                    end else if (b_zero && !a_inf) begin
                        res_d   = {s1 ^ s2, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        flags_d = 4'(1 << FLAG_DZ);
                    end else if (a_inf) begin
                        res_d   = {s1 ^ s2, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        flags_d = 4'b0000;
                    end else if (a_zero || b_inf) begin
                        res_d   = {s1 ^ s2, {(W-1){1'b0}}};
                        flags_d = 4'b0000;
                    end
                    if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero) begin
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        e_d     = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;
                        rem_d   = {1'b0, 1'b1, f1};
                        dvs_d   = {1'b1, f2};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                quo_d = {quo_q[N-2:0], step_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (e_r >= E_MAX) begin
                    res_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags_d = 4'(1 << FLAG_OF);
                end else if (e_r <= ZERO_S) begin
                    res_d   = {sign_q, {(W-1){1'b0}}};
                    flags_d = 4'(1 << FLAG_UF);
                end else begin
                    res_d   = {sign_q, e_r[EXP_W-1:0], frac_r};
                    flags_d = 4'b0000;
                end
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and visible outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
        end
    end

    // Datapath registers are always reloaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        e_q    <= e_d;
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
        quo_q  <= quo_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;

endmodule
